// File: rtl/shiftreg_arbiter.sv
// Round-robin arbiter sharing one 74HC595 serial driver among NREQ requesters.
// Runs the driver's EN/RDY handshake for one byte per grant, then pulses ACK.
module shiftreg_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned IDW           = 2,
    parameter int unsigned ISSUE_TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]   o_ack,
    output logic              o_err,
    output logic              o_busy,
    output logic [IDW-1:0]    o_grant_id,
    output logic [7:0]        o_drv_byte,
    output logic              o_drv_en,
    input  logic              i_drv_rdy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACKS  = 2'd3;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_grant_id;
    logic [7:0]      r_cnt;
    logic [7:0]      r_drv_byte;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            r_busy;
    logic            r_drv_en;

    logic            w_found;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_winner;
    logic [7:0]      w_win_byte;
    logic [NREQ-1:0] w_ack_vec;
    logic            w_timeout;

    // First set request searching upward from the slot after the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        w_winner = r_ptr;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_byte = '0;
        w_ack_vec  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_win_byte = i_req_data[8*i +: 8];
            end
            w_ack_vec[i] = (r_grant_id == IDW'(i));
        end
    end

    assign w_timeout = (r_cnt == 8'(ISSUE_TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDW'(NREQ - 1);
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_drv_byte <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_drv_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The driver has no reset, so never start it while it is still shifting.
                    if (w_found && i_drv_rdy) begin
                        r_drv_byte <= w_win_byte;
                        r_grant_id <= w_winner;
                        r_ptr      <= w_winner;
                        r_drv_en   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!i_drv_rdy) begin
                        r_drv_en <= 1'b0;
                        r_state  <= S_WAIT;
                    end else if (w_timeout) begin
                        r_drv_en <= 1'b0;
                        r_ack    <= w_ack_vec;
                        r_err    <= 1'b1;
                        r_state  <= S_ACKS;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (i_drv_rdy) begin
                        r_ack   <= w_ack_vec;
                        r_err   <= 1'b0;
                        r_state <= S_ACKS;
                    end
                end
                S_ACKS: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_err      = r_err;
    assign o_busy     = r_busy;
    assign o_grant_id = r_grant_id;
    assign o_drv_byte = r_drv_byte;
    assign o_drv_en   = r_drv_en;

endmodule

// File: tb/tb_shiftreg_arbiter.sv
// Bench for shiftreg_arbiter: cycle vector table, directed corner sequences and a
// randomized run checked against a transaction-level round-robin model.
module tb_shiftreg_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 15;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic              rdy;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic [IDW-1:0]    gid;
    logic [7:0]        dbyte;
    logic              en;

    int checks = 0;
    int errors = 0;

    // Driver model: 0 = behavioural 595 driver, 1 = RDY stuck high, 2 = RDY stuck low,
    // 3 = RDY driven by the vector table.
    int drv_mode;
    int drv_cnt;
    int shift_len;
    bit drv_arm;

    typedef struct {
        logic [NREQ-1:0] req;
        logic            rdy;
        logic            en;
        logic            busy;
        logic [NREQ-1:0] ack;
        logic            err;
        logic [7:0]      dbyte;
        logic [IDW-1:0]  gid;
    } vec_t;

    vec_t tv[14];

    int              n;
    int              en_cycles;
    logic            got;
    int              ptr_m;
    int              cur;
    int              w;
    int              maxw;
    int              acks_rand;
    int              waits[NREQ];
    logic [7:0]      data_m[NREQ];
    logic [NREQ-1:0] req_prev;
    logic            prev_en;
    int              exp_seq[3];

    shiftreg_arbiter #(
        .NREQ         (NREQ),
        .IDW          (IDW),
        .ISSUE_TIMEOUT(TO)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_req_data(req_data),
        .o_ack     (ack),
        .o_err     (err),
        .o_busy    (busy),
        .o_grant_id(gid),
        .o_drv_byte(dbyte),
        .o_drv_en  (en),
        .i_drv_rdy (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RDY falls one cycle after the driver first sees EN high, stays low shift_len cycles.
    task automatic drv_step();
        case (drv_mode)
            1: rdy = 1'b1;
            2: rdy = 1'b0;
            3: ;
            default: begin
                if (drv_cnt > 0) begin
                    drv_cnt--;
                    if (drv_cnt == 0) rdy = 1'b1;
                end else if (drv_arm) begin
                    drv_arm = 1'b0;
                    rdy     = 1'b0;
                    drv_cnt = shift_len;
                end else if (rdy && en) begin
                    drv_arm = 1'b1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        drv_step();
    endtask

    task automatic set_normal();
        drv_mode  = 0;
        drv_cnt   = 0;
        drv_arm   = 1'b0;
        rdy       = 1'b1;
        shift_len = 40;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input string name, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        // {req, rdy} -> {en, busy, ack, err, byte, grant_id} after the next edge
        tv[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
        tv[1]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[2]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[3]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[5]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b0, 8'hA5, 2'd0};
        tv[6]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd0};
        tv[9]  = '{4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};
        tv[10] = '{4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};
        tv[11] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};
        tv[12] = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 8'h33, 2'd2};
        tv[13] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h33, 2'd2};

        set_normal();
        req      = '0;
        req_data = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_en", 32'(en), 32'(0));
        chk("rst_byte", 32'(dbyte), 32'(0));
        chk("rst_gid", 32'(gid), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table, RDY driven directly
        drv_mode = 3;
        req_data = 32'h4433_22A5;
        for (int i = 0; i < 14; i++) begin
            req = tv[i].req;
            rdy = tv[i].rdy;
            tick();
            chk($sformatf("tv%0d_en", i), 32'(en), 32'(tv[i].en));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("tv%0d_ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("tv%0d_err", i), 32'(err), 32'(tv[i].err));
            chk($sformatf("tv%0d_byte", i), 32'(dbyte), 32'(tv[i].dbyte));
            chk($sformatf("tv%0d_gid", i), 32'(gid), 32'(tv[i].gid));
        end

        // Single request through the behavioural driver
        set_normal();
        do_reset();
        req_data  = 32'h4433_22A5;
        req       = 4'b0001;
        en_cycles = 0;
        got       = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (en) en_cycles++;
            if (ack != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("single_got_ack", 32'(got), 32'(1));
        chk("single_ack", 32'(ack), 32'(1));
        chk("single_err", 32'(err), 32'(0));
        chk("single_byte", 32'(dbyte), 32'hA5);
        chk("single_en_cycles", 32'(en_cycles), 32'(2));
        req = '0;
        tick();
        chk("single_ack_pulse", 32'(ack), 32'(0));
        chk("single_busy_after", 32'(busy), 32'(0));

        // Contention: all four held high
        set_normal();
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (n = 0; n < 5; n++) begin
            wait_ack("cont", got);
            chk($sformatf("cont%0d_ack", n), 32'(ack), 32'(1) << (n % 4));
            chk($sformatf("cont%0d_gid", n), 32'(gid), 32'(n % 4));
            chk($sformatf("cont%0d_byte", n), 32'(dbyte), 32'h11 * 32'((n % 4) + 1));
        end
        req = '0;

        // Fairness after skip: leave pointer at 1, then REQ=1001
        set_normal();
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b0010;
        wait_ack("skip_pre", got);
        chk("skip_pre_ack", 32'(ack), 32'(2));
        req = '0;
        tick();
        req        = 4'b1001;
        exp_seq[0] = 3;
        exp_seq[1] = 0;
        exp_seq[2] = 3;
        for (int i = 0; i < 3; i++) begin
            wait_ack("skip", got);
            chk($sformatf("skip%0d_ack", i), 32'(ack), 32'(1) << exp_seq[i]);
            chk($sformatf("skip%0d_byte", i), 32'(dbyte), 32'h11 * 32'(exp_seq[i] + 1));
        end
        req = '0;

        // Driver still busy when reset is released
        drv_mode = 2;
        rdy      = 1'b0;
        req      = 4'b0010;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("drvbusy_en%0d", c), 32'(en), 32'(0));
        end
        drv_mode  = 0;
        drv_cnt   = 0;
        drv_arm   = 1'b0;
        shift_len = 40;
        rdy       = 1'b1;
        tick();
        chk("drvbusy_grant_en", 32'(en), 32'(1));
        chk("drvbusy_grant_gid", 32'(gid), 32'(1));
        chk("drvbusy_grant_byte", 32'(dbyte), 32'h22);
        wait_ack("drvbusy", got);
        chk("drvbusy_ack", 32'(ack), 32'(2));
        req = '0;

        // Issue timeout with RDY stuck high
        drv_mode = 1;
        rdy      = 1'b1;
        do_reset();
        req       = 4'b0100;
        en_cycles = 0;
        got       = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (en) en_cycles++;
            if (ack != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("to_got_ack", 32'(got), 32'(1));
        chk("to_en_cycles", 32'(en_cycles), 32'(TO));
        chk("to_ack", 32'(ack), 32'(4));
        chk("to_err", 32'(err), 32'(1));
        chk("to_en_low", 32'(en), 32'(0));
        req = '0;
        tick();
        chk("to_busy_after", 32'(busy), 32'(0));
        chk("to_err_pulse", 32'(err), 32'(0));
        chk("to_ack_pulse", 32'(ack), 32'(0));

        // Reset while waiting for the driver to finish
        set_normal();
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b0001;
        got      = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (busy && !en) begin
                got = 1'b1;
                break;
            end
        end
        chk("midrst_reach_wait", 32'(got), 32'(1));
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'(0));
        chk("midrst_en", 32'(en), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        tick();
        rst_n = 1'b1;
        got   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("midrst_hold_en", 32'(en), 32'(0));
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        chk("midrst_rdy_back", 32'(got), 32'(1));
        tick();
        chk("midrst_regrant_en", 32'(en), 32'(1));
        chk("midrst_regrant_gid", 32'(gid), 32'(0));
        wait_ack("midrst", got);
        chk("midrst_ack_after", 32'(ack), 32'(1));
        req = '0;

        // Randomized traffic against a round-robin transaction model
        set_normal();
        do_reset();
        ptr_m     = NREQ - 1;
        cur       = -1;
        acks_rand = 0;
        prev_en   = 1'b0;
        req_prev  = '0;
        for (int i = 0; i < NREQ; i++) begin
            waits[i]  = 0;
            data_m[i] = 8'h00;
        end
        for (int c = 0; c < 4000; c++) begin
            tick();
            shift_len = int'($urandom_range(3, 12));
            if (en && !prev_en) begin
                w = rr_pick(req_prev, ptr_m);
                chk("rand_grant_valid", 32'(w >= 0), 32'(1));
                if (w >= 0) begin
                    chk("rand_gid", 32'(gid), 32'(w));
                    chk("rand_byte", 32'(dbyte), 32'(data_m[w]));
                    maxw = 0;
                    for (int j = 0; j < NREQ; j++) begin
                        if (j != w && req_prev[j]) waits[j]++;
                        if (waits[j] > maxw) maxw = waits[j];
                    end
                    waits[w] = 0;
                    chk("rand_fair", 32'(maxw <= NREQ - 1), 32'(1));
                    ptr_m = w;
                    cur   = w;
                end
            end
            if (ack != '0) begin
                chk("rand_ack_owner", 32'(cur >= 0), 32'(1));
                if (cur >= 0) begin
                    chk("rand_ack", 32'(ack), 32'(1) << cur);
                    req[cur] = 1'b0;
                end
                chk("rand_err", 32'(err), 32'(0));
                acks_rand++;
            end
            prev_en = en;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && !ack[i] && $urandom_range(0, 3) == 0) begin
                    data_m[i]          = 8'($urandom);
                    req_data[8*i +: 8] = data_m[i];
                    req[i]             = 1'b1;
                end
            end
            req_prev = req;
        end
        chk("rand_enough_acks", 32'(acks_rand > 50), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_arbiter.md
Name: shiftreg_arbiter

Overview:
- Round-robin arbiter that shares one 74HC595 serial driver among NREQ independent requesters.
- Each requester posts one byte with a level REQ. The arbiter grants one requester, runs the driver's EN_IN/BYTE_IN/RDY handshake for one full byte shift, then returns a one-cycle ACK.
- Sits between the application logic (LED/relay bank owners) and the shift-register driver, on the same clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of GRANT_ID; must satisfy 2^IDW >= NREQ.
- ISSUE_TIMEOUT, 15, max CLK cycles in ISSUE waiting for DRV_RDY to fall; range 2..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester level request; held until that requester's ACK.
- REQ_DATA  in  8*NREQ  byte for requester i in bits [8i+7:8i]; stable while REQ[i]=1.
- ACK  out  NREQ  one-cycle pulse; the requester's byte is latched to the 595 outputs (or aborted, see ERR).
- ERR  out  1  one-cycle pulse coincident with ACK when the transfer aborted on timeout.
- BUSY  out  1  high in every state except IDLE.
- GRANT_ID  out  IDW  index of the current or last granted requester.
- DRV_BYTE  out  8  to driver BYTE_IN.
- DRV_EN  out  1  to driver EN_IN.
- DRV_RDY  in  1  from driver RDY.

Behaviour:
- Reset (async, RST_N=0) values:
  - ACK=0, ERR=0, BUSY=0, DRV_EN=0, DRV_BYTE=0, GRANT_ID=0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - State = IDLE, timeout counter = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, ACKS.
- IDLE:
  - Grants only when |REQ and DRV_RDY=1. The driver has no reset and may still be mid-shift after a controller reset.
  - Winner = first set REQ bit searching upward from pointer+1 modulo NREQ.
  - On grant, all in the same edge: latch REQ_DATA slice into DRV_BYTE, GRANT_ID <= winner, pointer <= winner, DRV_EN <= 1, BUSY <= 1, go to ISSUE.
- ISSUE:
  - Hold DRV_EN=1 and DRV_BYTE stable; count cycles.
  - On DRV_RDY=0: DRV_EN <= 0, go to WAIT. The driver re-triggers if EN_IN is still high when it returns to idle, so DRV_EN must drop here.
  - If the count reaches ISSUE_TIMEOUT with DRV_RDY still 1: DRV_EN <= 0, set the abort flag, go to ACKS.
- WAIT:
  - DRV_EN=0. On DRV_RDY=1 go to ACKS.
  - No timeout: a full byte takes roughly 8*(setup+pulse)+RCLK cycles, which is bounded by the driver.
- ACKS:
  - ACK[GRANT_ID]=1 for exactly one cycle, and ERR=abort flag.
  - Clear the abort flag, BUSY <= 0, go to IDLE.
- Minimum latency, REQ rising to ACK, with the driver idle:
  - 1 cycle to grant.
  - Driver RDY falls 2 cycles after DRV_EN rises (driver samples, then its registered RDY falls).
  - Then the shift time, plus 1 cycle for ACKS.
- Requester i may deassert REQ in the cycle after its ACK. A REQ still high in IDLE the cycle after ACK is a new request.
- REQ changes for the granted requester after grant are ignored; data is already latched.
- A requester that drops REQ before grant is simply not granted. No ACK is issued.
- Simultaneous requests: exactly one grant per IDLE visit. Fairness means no requester waits more than NREQ-1 transfers.
- DRV_BYTE holds its last value after the transfer.
- Reset mid-transfer:
  - All outputs go to reset values immediately; no ACK is issued. DRV_EN=0.
  - The next grant waits for DRV_RDY=1.

Test Plan:
- Single request: REQ=0001, REQ_DATA[7:0]=8'hA5, DRV_RDY model (falls 2 cycles after EN, rises 40 cycles later) -> DRV_EN high for exactly 2 cycles, DRV_BYTE=8'hA5, ACK=0001 single pulse, ERR=0, BUSY low the cycle after ACK.
- Contention: REQ=1111 held, data 8'h11/22/33/44 -> DRV_BYTE sequence 11,22,33,44,11; ACK order 0,1,2,3,0; GRANT_ID 0,1,2,3,0.
- Fairness after skip: pointer=1, REQ=1001 -> grant 3, then 0, then 3.
- Driver busy at reset release: DRV_RDY=0 for 20 cycles with REQ=0010 -> DRV_EN stays 0 until the cycle after DRV_RDY=1, then grant 1.
- Timeout: DRV_RDY stuck at 1, ISSUE_TIMEOUT=15, REQ=0100 -> DRV_EN high 15 cycles, then ACK=0100 with ERR=1 the same cycle, return to IDLE.
- Reset mid-WAIT: assert RST_N=0 while BUSY=1 -> ACK=0, DRV_EN=0, BUSY=0 immediately. After release with REQ=0001 held, re-grant to 0 only once DRV_RDY=1.
